// File: rtl/sel_key_stepper.sv
// Push-key channel stepper: two debounced keys step a 2-bit mux select up/down.

// Per-key synchroniser, debouncer and press-edge detector.
//  state | meaning
//  REL   | key released and stable, waiting for a low level
//  P_CHK | key seen low, counting stable-low clocks before accepting a press
//  PRS   | press accepted, holding (no auto-repeat)
//  R_CHK | key seen high, counting stable-high clocks before accepting release
module sel_key_deb #(
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int CNT_W           = 18
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n_i,
  output logic press_o
);

  typedef enum logic [1:0] {REL, P_CHK, PRS, R_CHK} state_t;

  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             k_s1_q, k_s2_q;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Two-flop synchroniser (preset to released), FSM state and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_s1_q  <= 1'b1;
      k_s2_q  <= 1'b1;
      state_q <= REL;
      cnt_q   <= '0;
    end else begin
      k_s1_q  <= key_n_i;
      k_s2_q  <= k_s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, counter and one-cycle press event.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_o = 1'b0;
    unique case (state_q)
      REL: begin
        if (!k_s2_q) begin
          state_d = P_CHK;
          cnt_d   = '0;
        end
      end
      P_CHK: begin
        if (k_s2_q) begin
          state_d = REL;
        end else if (cnt_q == CNT_TC) begin
          state_d = PRS;
          press_o = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRS: begin
        if (k_s2_q) begin
          state_d = R_CHK;
          cnt_d   = '0;
        end
      end
      R_CHK: begin
        if (!k_s2_q) begin
          state_d = PRS;
        end else if (cnt_q == CNT_TC) begin
          state_d = REL;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = REL;
    endcase
  end

endmodule

module sel_key_stepper #(
  parameter int         DEBOUNCE_CYCLES = 240000,
  parameter int         CNT_W           = 18,
  parameter logic [1:0] RST_SEL         = 2'b00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_up,
  input  logic       key_dn,
  output logic [1:0] sel,
  output logic       sel_chg,
  output logic [3:0] sel_led
);

  logic       up_ev, dn_ev;
  logic [1:0] sel_q, sel_d;
  logic       chg_q, chg_d;
  logic [3:0] led_q, led_d;

  sel_key_deb #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb_up (
    .clk     (clk),
    .rst     (rst),
    .key_n_i (key_up),
    .press_o (up_ev)
  );

  sel_key_deb #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb_dn (
    .clk     (clk),
    .rst     (rst),
    .key_n_i (key_dn),
    .press_o (dn_ev)
  );

  // Step the select; simultaneous up and down presses cancel out.
  always_comb begin
    sel_d = sel_q;
    chg_d = 1'b0;
    if (up_ev && !dn_ev) begin
      sel_d = sel_q + 2'd1;
      chg_d = 1'b1;
    end else if (dn_ev && !up_ev) begin
      sel_d = sel_q - 2'd1;
      chg_d = 1'b1;
    end
    led_d = ~(4'b0001 << sel_d);
  end

  // Output registers; the LED pattern is taken from the next select so it tracks sel.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q <= RST_SEL;
      chg_q <= 1'b0;
      led_q <= ~(4'b0001 << RST_SEL);
    end else begin
      sel_q <= sel_d;
      chg_q <= chg_d;
      led_q <= led_d;
    end
  end

  assign sel     = sel_q;
  assign sel_chg = chg_q;
  assign sel_led = led_q;

endmodule
